// File: rtl/bnn_control_unit.sv
// Address sequencer for the binarized 3x3 convolution layer.
// Walks a KxK window across the image in raster order, one graph-memory read
// address per clock, and pulses WR with the output address as each window completes.
module bnn_control_unit #(
  parameter int IMG_SIZE = 32,
  parameter int K        = 3,
  parameter int ADDR_W   = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic [ADDR_W-1:0] graph_mem_rowaddr_o,
  output logic [ADDR_W-1:0] graph_mem_coladdr_o,
  output logic [ADDR_W-1:0] out_mem_rowaddr_o,
  output logic [ADDR_W-1:0] out_mem_coladdr_o,
  output logic              WR_o
);

  localparam int OUT_SIZE = IMG_SIZE - K + 1;
  localparam int KW       = (K > 2) ? $clog2(K) : 1;

  localparam logic [ADDR_W-1:0] OUT_LAST = ADDR_W'(OUT_SIZE - 1);
  localparam logic [KW-1:0]     K_LAST   = KW'(K - 1);

  typedef enum logic {RUN, DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] orow_q, orow_d, ocol_q, ocol_d;
  logic [KW-1:0]     ki_q, ki_d, kj_q, kj_d;
  logic [ADDR_W-1:0] grow_q, grow_d, gcol_q, gcol_d;
  logic [ADDR_W-1:0] orow_out_q, orow_out_d, ocol_out_q, ocol_out_d;
  logic              wr_q, wr_d;
  logic              win_last;

  // Next-state: advance the window offsets, then the window origin; the graph
  // address register is loaded from the next counters so it lines up with them.
  always_comb begin
    state_d    = state_q;
    orow_d     = orow_q;
    ocol_d     = ocol_q;
    ki_d       = ki_q;
    kj_d       = kj_q;
    orow_out_d = orow_out_q;
    ocol_out_d = ocol_out_q;
    wr_d       = 1'b0;
    win_last   = (ki_q == K_LAST) && (kj_q == K_LAST);

    if (state_q == RUN) begin
      if (!win_last) begin
        if (kj_q == K_LAST) begin
          kj_d = '0;
          ki_d = ki_q + 1'b1;
        end else begin
          kj_d = kj_q + 1'b1;
        end
      end else begin
        // The 9th pixel is sampled by the datapath during the WR cycle.
        wr_d       = 1'b1;
        orow_out_d = orow_q;
        ocol_out_d = ocol_q;
        if ((orow_q == OUT_LAST) && (ocol_q == OUT_LAST)) begin
          // Counters freeze so the graph address holds the final pixel.
          state_d = DONE;
        end else begin
          ki_d = '0;
          kj_d = '0;
          if (ocol_q == OUT_LAST) begin
            ocol_d = '0;
            orow_d = orow_q + 1'b1;
          end else begin
            ocol_d = ocol_q + 1'b1;
          end
        end
      end
    end

    grow_d = orow_d + ADDR_W'(ki_d);
    gcol_d = ocol_d + ADDR_W'(kj_d);
  end

  // State, counters and registered outputs; reset restarts at window (0,0).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= RUN;
      orow_q     <= '0;
      ocol_q     <= '0;
      ki_q       <= '0;
      kj_q       <= '0;
      grow_q     <= '0;
      gcol_q     <= '0;
      orow_out_q <= '0;
      ocol_out_q <= '0;
      wr_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      orow_q     <= orow_d;
      ocol_q     <= ocol_d;
      ki_q       <= ki_d;
      kj_q       <= kj_d;
      grow_q     <= grow_d;
      gcol_q     <= gcol_d;
      orow_out_q <= orow_out_d;
      ocol_out_q <= ocol_out_d;
      wr_q       <= wr_d;
    end
  end

  assign graph_mem_rowaddr_o = grow_q;
  assign graph_mem_coladdr_o = gcol_q;
  assign out_mem_rowaddr_o   = orow_out_q;
  assign out_mem_coladdr_o   = ocol_out_q;
  assign WR_o                = wr_q;

endmodule

// File: tb/tb_bnn_control_unit.sv
// Scoreboard bench for bnn_control_unit: directed per-cycle expectations and
// a queue of expected WR addresses, both consumed by a free-running monitor.
module tb_bnn_control_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] g_row, g_col, o_row, o_col;
  logic       wr;

  bnn_control_unit dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .graph_mem_rowaddr_o(g_row),
    .graph_mem_coladdr_o(g_col),
    .out_mem_rowaddr_o  (o_row),
    .out_mem_coladdr_o  (o_col),
    .WR_o               (wr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       cyc;
    int       gr, gc, orr, oc;
    int       w;
    bit       ck_out;
  } dir_t;

  typedef struct {
    int cyc;
    int r, c;
  } wr_t;

  dir_t dq[$];
  wr_t  wq[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = -1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_dir(input int c, input int gr, input int gc, input int w,
                          input bit ck, input int orr, input int oc);
    dir_t d;
    d.cyc = c; d.gr = gr; d.gc = gc; d.w = w; d.ck_out = ck; d.orr = orr; d.oc = oc;
    dq.push_back(d);
  endtask

  // Window start addresses for the first window, hand-listed.
  task automatic push_first_window();
    int rr[9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
    int cc[9] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
    push_dir(0, 0, 0, 0, 1'b1, 0, 0);
    for (int i = 1; i < 9; i++) push_dir(i, rr[i], cc[i], 0, 1'b0, 0, 0);
  endtask

  task automatic fill_wq();
    wr_t e;
    wq.delete();
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 30; c++) begin
        e.cyc = 9 * (r * 30 + c + 1); e.r = r; e.c = c;
        wq.push_back(e);
      end
  endtask

  // Cycle index: 0 in the interval after any reset edge, +1 per running edge.
  always @(posedge clk) begin
    if (rst) cyc = 0;
    else if (cyc >= 0) cyc = cyc + 1;
  end

  // Monitor: consume directed entries due this cycle and every WR pulse.
  always @(negedge clk) begin
    if (cyc >= 0) begin
      while (dq.size() > 0 && dq[0].cyc == cyc) begin
        dir_t d;
        d = dq.pop_front();
        chk($sformatf("grow@%0d", cyc), int'(g_row), d.gr);
        chk($sformatf("gcol@%0d", cyc), int'(g_col), d.gc);
        chk($sformatf("wr@%0d", cyc), int'(wr), d.w);
        if (d.ck_out) begin
          chk($sformatf("orow@%0d", cyc), int'(o_row), d.orr);
          chk($sformatf("ocol@%0d", cyc), int'(o_col), d.oc);
        end
      end
      if (wr === 1'b1) begin
        if (wq.size() == 0) begin
          chk("extra_wr_pulse", 1, 0);
        end else begin
          wr_t e;
          e = wq.pop_front();
          chk("wr_cycle", cyc, e.cyc);
          chk("wr_orow", int'(o_row), e.r);
          chk("wr_ocol", int'(o_col), e.c);
        end
      end
    end
  end

  initial begin
    // First scan: window start, first two writes, row wrap.
    push_first_window();
    push_dir(9,   0, 1,  1, 1'b1, 0, 0);
    push_dir(10,  0, 2,  0, 1'b1, 0, 0);
    push_dir(18,  0, 2,  1, 1'b1, 0, 1);
    push_dir(261, 0, 29, 1, 1'b1, 0, 28);
    push_dir(270, 1, 0,  1, 1'b1, 0, 29);
    fill_wq();

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_grow", int'(g_row), 0);
    chk("rst_gcol", int'(g_col), 0);
    chk("rst_orow", int'(o_row), 0);
    chk("rst_ocol", int'(o_col), 0);
    chk("rst_wr",   int'(wr),    0);
    rst = 1'b0;

    for (int i = 0; i < 2000 && cyc != 500; i++) @(negedge clk);
    chk("reach_cycle_500", cyc, 500);

    // Mid-run reset for one edge; second scan runs to completion.
    rst = 1'b1;
    fill_wq();
    push_first_window();
    push_dir(9,    0,  1,  1, 1'b1, 0,  0);
    push_dir(8099, 31, 31, 0, 1'b0, 0,  0);
    push_dir(8100, 31, 31, 1, 1'b1, 29, 29);
    push_dir(8101, 31, 31, 0, 1'b1, 29, 29);
    push_dir(8220, 31, 31, 0, 1'b1, 29, 29);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9000 && cyc < 8221; i++) @(negedge clk);
    chk("reach_cycle_8221", int'(cyc >= 8221), 1);
    chk("wr_pulses_missing", wq.size(), 0);
    chk("directed_left", dq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
